// File: rtl/switch_pkg.sv
// Shared types and constants for the 4x4 packet switch.
package switch_pkg;

  localparam int unsigned NPORTS = 4;
  localparam int unsigned DW     = 8;

  typedef logic [1:0]    port_id_t;
  typedef logic [DW-1:0] byte_t;

  typedef struct packed {
    logic  valid;
    logic  sop;
    logic  eop;
    byte_t data;
  } flit_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one output port. A grant locks the output to the winning input
// until rel (eop transferred) is seen; the next search starts just after the last winner.
module rr_arbiter
  import switch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NPORTS-1:0] req,
  input  logic              rel,
  output logic              locked,
  output port_id_t          owner
);

  logic     locked_q;
  port_id_t owner_q;
  port_id_t ptr_q;
  port_id_t winner;
  port_id_t cand;
  logic     found;

  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    cand   = ptr_q;
    for (int k = 0; k < NPORTS; k++) begin
      cand = ptr_q + port_id_t'(k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      locked_q <= 1'b0;
      owner_q  <= '0;
      ptr_q    <= '0;
    end else if (locked_q) begin
      if (rel) locked_q <= 1'b0;
    end else if (found) begin
      locked_q <= 1'b1;
      owner_q  <= winner;
      ptr_q    <= winner + 2'd1;
    end
  end

  assign locked = locked_q;
  assign owner  = owner_q;

endmodule

// File: rtl/switch_4x4.sv
// 4x4 packet crossbar: per-output round-robin arbitration with packet locking and a
// 2-entry registered skid buffer on every output.
module switch_4x4
  import switch_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    in_valid,
  input  logic [NPORTS-1:0]    in_sop,
  input  logic [NPORTS-1:0]    in_eop,
  input  logic [NPORTS*DW-1:0] in_data,
  output logic [NPORTS-1:0]    in_ready,
  output logic [NPORTS-1:0]    out_valid,
  output logic [NPORTS-1:0]    out_sop,
  output logic [NPORTS-1:0]    out_eop,
  output logic [NPORTS*DW-1:0] out_data,
  input  logic [NPORTS-1:0]    out_ready
);

  logic     [NPORTS-1:0] locked;
  logic     [NPORTS-1:0] room;
  logic     [NPORTS-1:0] in_locked;
  port_id_t [NPORTS-1:0] owner;

  // Lock table view from the input side; ready depends only on registered state.
  always_comb begin
    in_locked = '0;
    in_ready  = '0;
    for (int d = 0; d < NPORTS; d++) begin
      if (locked[d]) begin
        in_locked[owner[d]] = 1'b1;
        in_ready[owner[d]]  = room[d];
      end
    end
  end

  for (genvar d = 0; d < NPORTS; d++) begin : g_out
    logic [NPORTS-1:0] req;
    port_id_t          sel;
    flit_t             in_flit;
    flit_t             head_q;
    flit_t             tail_q;
    logic [1:0]        cnt_q;
    logic              push;
    logic              pop;
    logic              rel;

    always_comb begin
      req = '0;
      for (int i = 0; i < NPORTS; i++) begin
        req[i] = in_valid[i] && in_sop[i] && !in_locked[i] &&
                 (in_data[i*DW +: 2] == port_id_t'(d));
      end
    end

    rr_arbiter u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .rel    (rel),
      .locked (locked[d]),
      .owner  (owner[d])
    );

    assign sel     = owner[d];
    assign in_flit = '{valid: in_valid[sel], sop: in_sop[sel], eop: in_eop[sel],
                       data: in_data[int'(sel)*DW +: DW]};
    assign room[d] = (cnt_q != 2'd2);
    assign push    = locked[d] && in_valid[sel] && room[d];
    assign rel     = push && in_eop[sel];
    assign pop     = head_q.valid && out_ready[d];

    // head_q drives the port directly; tail_q only fills while the sink stalls.
    always_ff @(posedge clk) begin
      if (reset) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= 2'd0;
      end else begin
        unique case (cnt_q)
          2'd0: begin
            if (push) begin
              head_q <= in_flit;
              cnt_q  <= 2'd1;
            end
          end
          2'd1: begin
            if (push && pop) begin
              head_q <= in_flit;
            end else if (push) begin
              tail_q <= in_flit;
              cnt_q  <= 2'd2;
            end else if (pop) begin
              head_q.valid <= 1'b0;
              cnt_q        <= 2'd0;
            end
          end
          default: begin
            if (pop) begin
              head_q <= tail_q;
              cnt_q  <= 2'd1;
            end
          end
        endcase
      end
    end

    assign out_valid[d]          = head_q.valid;
    assign out_sop[d]            = head_q.valid && head_q.sop;
    assign out_eop[d]            = head_q.valid && head_q.eop;
    assign out_data[d*DW +: DW]  = head_q.data;
  end

endmodule

// File: tb/tb_switch_4x4.sv
// Directed bench for switch_4x4: packet sources per input, per-output capture streams.
module tb_switch_4x4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid, in_sop, in_eop, in_ready;
  logic [31:0] in_data;
  logic [3:0]  out_valid, out_sop, out_eop, out_ready;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  switch_4x4 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          n;
  logic [7:0]  src_data [4][8];
  int          src_len [4];
  int          src_ptr [4];
  logic [3:0]  raw;
  logic [9:0]  cap [4][16];
  int          cap_cnt [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic v;
    for (int i = 0; i < 4; i++) begin
      if (!raw[i]) begin
        v               = src_ptr[i] < src_len[i];
        in_valid[i]     = v;
        in_sop[i]       = v && (src_ptr[i] == 0);
        in_eop[i]       = v && (src_ptr[i] == src_len[i] - 1);
        in_data[i*8+:8] = v ? src_data[i][src_ptr[i]] : 8'h00;
      end
    end
  endtask

  // Record transfers seen this cycle, advance one clock, then present the next bytes.
  task automatic tick();
    logic [3:0] inf, outf;
    inf  = in_valid & in_ready;
    outf = out_valid & out_ready;
    for (int j = 0; j < 4; j++) begin
      if (outf[j] && cap_cnt[j] < 16) begin
        cap[j][cap_cnt[j]] = {out_sop[j], out_eop[j], out_data[j*8+:8]};
        cap_cnt[j]++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (inf[i]) src_ptr[i]++;
    drive();
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 0;
      src_ptr[i] = 0;
      cap_cnt[i] = 0;
    end
  endtask

  task automatic load(input int i, input int len, input logic [7:0] b [8]);
    for (int k = 0; k < 8; k++) src_data[i][k] = b[k];
    src_len[i] = len;
    src_ptr[i] = 0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    clear_all();
    out_ready = 4'hF;
    drive();
    tick();
    tick();
    reset = 1'b0;
    clear_all();
  endtask

  task automatic run_idle(input int budget, output int cycles);
    bit done;
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < budget) begin
      done = (out_valid == 4'h0);
      for (int i = 0; i < 4; i++) if (src_ptr[i] < src_len[i]) done = 1'b0;
      if (!done) begin
        tick();
        cycles++;
      end
    end
    check("idle_in_budget", {31'd0, done}, 32'd1);
  endtask

  task automatic check_stream(input int j, input int len, input logic [9:0] e [8],
                              input string tag);
    check({tag, "_len"}, cap_cnt[j], len);
    for (int k = 0; k < len && k < cap_cnt[j]; k++)
      check($sformatf("%s_byte%0d", tag, k), {22'd0, cap[j][k]}, {22'd0, e[k]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    raw       = 4'h0;
    in_valid  = '0;
    in_sop    = '0;
    in_eop    = '0;
    in_data   = '0;
    out_ready = 4'hF;
    reset     = 1'b1;
    clear_all();
    tick();
    tick();
    check("rst_out_valid", out_valid, 4'h0);
    check("rst_out_sop", out_sop, 4'h0);
    check("rst_out_eop", out_eop, 4'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_in_ready", in_ready, 4'h0);
    reset = 1'b0;

    // Non-sop byte on an unlocked input is stalled, never forwarded
    raw[1]       = 1'b1;
    in_valid[1]  = 1'b1;
    in_sop[1]    = 1'b0;
    in_data[15:8] = 8'h02;
    tick();
    tick();
    check("nosop_in_ready", in_ready, 4'h0);
    check("nosop_out_valid", out_valid, 4'h0);
    raw[1]      = 1'b0;
    in_valid[1] = 1'b0;

    // Single packet in0 -> out2
    load(0, 4, '{8'h02, 8'hA1, 8'hA2, 8'hA3, 8'h0, 8'h0, 8'h0, 8'h0});
    drive();
    check("single_arb_ready", in_ready, 4'h0);
    tick();
    check("single_grant_ready", in_ready, 4'h1);
    check("single_no_out_yet", out_valid, 4'h0);
    tick();
    check("single_first_out", {out_valid[2], out_sop[2], out_data[23:16]}, 10'h302);
    run_idle(20, n);
    check("single_cycles", n, 4);
    check_stream(2, 4, '{10'h202, 10'h0A1, 10'h0A2, 10'h1A3, 10'h0, 10'h0, 10'h0, 10'h0},
                 "single");

    // Four concurrent flows to distinct outputs
    reset_dut();
    load(0, 4, '{8'h13, 8'h31, 8'h32, 8'h33, 8'h0, 8'h0, 8'h0, 8'h0});
    load(1, 4, '{8'h22, 8'h41, 8'h42, 8'h43, 8'h0, 8'h0, 8'h0, 8'h0});
    load(2, 4, '{8'h35, 8'h51, 8'h52, 8'h53, 8'h0, 8'h0, 8'h0, 8'h0});
    load(3, 4, '{8'h4C, 8'h61, 8'h62, 8'h63, 8'h0, 8'h0, 8'h0, 8'h0});
    drive();
    run_idle(30, n);
    check("par_cycles", n, 6);
    check_stream(3, 4, '{10'h213, 10'h031, 10'h032, 10'h133, 10'h0, 10'h0, 10'h0, 10'h0},
                 "par_out3");
    check_stream(2, 4, '{10'h222, 10'h041, 10'h042, 10'h143, 10'h0, 10'h0, 10'h0, 10'h0},
                 "par_out2");
    check_stream(1, 4, '{10'h235, 10'h051, 10'h052, 10'h153, 10'h0, 10'h0, 10'h0, 10'h0},
                 "par_out1");
    check_stream(0, 4, '{10'h24C, 10'h061, 10'h062, 10'h163, 10'h0, 10'h0, 10'h0, 10'h0},
                 "par_out0");

    // Contention in0 vs in2 on out1: in0 first from reset pointer
    reset_dut();
    load(0, 3, '{8'h01, 8'hB1, 8'hB2, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0});
    load(2, 2, '{8'h05, 8'hC1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0});
    drive();
    run_idle(30, n);
    check("cont_cycles", n, 8);
    check_stream(1, 5, '{10'h201, 10'h0B1, 10'h1B2, 10'h205, 10'h1C1, 10'h0, 10'h0, 10'h0},
                 "cont");

    // Pointer now after in2: in3 beats in0
    clear_all();
    load(0, 2, '{8'h01, 8'hD1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0});
    load(3, 2, '{8'h0D, 8'hE1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0});
    drive();
    run_idle(30, n);
    check_stream(1, 4, '{10'h20D, 10'h1E1, 10'h201, 10'h1D1, 10'h0, 10'h0, 10'h0, 10'h0},
                 "rr");

    // Backpressure on out1 for three cycles mid-packet
    reset_dut();
    load(1, 6, '{8'h11, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'h0, 8'h0});
    drive();
    tick();
    tick();
    tick();
    check("bp_ready_before", in_ready[1], 1'b1);
    out_ready[1] = 1'b0;
    tick();
    check("bp_ready_drop", in_ready[1], 1'b0);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp_hold%0d", c),
            {out_valid[1], out_sop[1], out_eop[1], out_data[15:8]}, 11'h4F1);
      if (c < 2) tick();
    end
    out_ready[1] = 1'b1;
    run_idle(30, n);
    check_stream(1, 6, '{10'h211, 10'h0F1, 10'h0F2, 10'h0F3, 10'h0F4, 10'h1F5, 10'h0, 10'h0},
                 "bp");

    // One-byte packet on in0 -> out3; lock frees for in1 the following cycle
    reset_dut();
    load(0, 1, '{8'h03, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0});
    load(1, 2, '{8'h07, 8'h71, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0});
    drive();
    tick();
    check("one_grant", in_ready, 4'h1);
    tick();
    check("one_out", {out_valid[3], out_sop[3], out_eop[3], out_data[31:24]}, 11'h703);
    check("one_release", in_ready, 4'h0);
    tick();
    check("one_regrant", in_ready, 4'h2);
    run_idle(30, n);
    check_stream(3, 3, '{10'h303, 10'h207, 10'h171, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0},
                 "one");

    // Reset in the middle of a packet, then a fresh packet
    reset_dut();
    load(0, 4, '{8'h02, 8'hA1, 8'hA2, 8'hA3, 8'h0, 8'h0, 8'h0, 8'h0});
    drive();
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midrst_out_valid", out_valid, 4'h0);
    check("midrst_in_ready", in_ready, 4'h0);
    check("midrst_out_data", out_data, 32'h0);
    reset = 1'b0;
    clear_all();
    load(3, 2, '{8'h06, 8'h81, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0});
    drive();
    run_idle(30, n);
    check("midrst_cycles", n, 4);
    check_stream(2, 2, '{10'h206, 10'h181, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0},
                 "midrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
